// File: rtl/push_sw_pkg.sv
// Shared event types for the push/DIP switch reader.
package push_sw_pkg;

   typedef enum logic [1:0] {
      EVT_PRESS   = 2'b00,
      EVT_RELEASE = 2'b01,
      EVT_LONG    = 2'b10
   } evt_type_e;

   typedef struct packed {
      logic      full;
      evt_type_e typ;
   } evt_slot_t;

   localparam evt_slot_t SLOT_EMPTY = '{full: 1'b0, typ: EVT_PRESS};

endpackage

// File: rtl/push_sw_chan.sv
// One switch channel: synchroniser, debounce, stable level and a one-cycle event strobe.
// Optional long-press hold counter when PUSH_SW_LONG_EN is defined.
module push_sw_chan
   import push_sw_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16,
   parameter int LONG_CYC     = 1000,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_pin,
   output logic       level,
   output logic       evt,
   output logic [1:0] evt_type
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC);

   logic             sync_1;
   logic             sync_2;
   logic             synced;
   logic             stable;
   logic [CNT_W-1:0] cnt;
   logic             db_done;

   assign synced  = (ACTIVE_LOW != 0) ? ~sync_2 : sync_2;
   assign db_done = (synced != stable) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));
   assign level   = stable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_1 <= sw_pin;
         sync_2 <= sync_1;
         if (synced == stable) begin
            cnt <= '0;
         end else if (db_done) begin
            stable <= synced;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef PUSH_SW_LONG_EN
   localparam int HOLD_W = $clog2(LONG_CYC + 1);

   logic [HOLD_W-1:0] hold;
   logic              long_hit;

   // Saturating at LONG_CYC makes the long-press strobe fire once per press.
   assign long_hit = stable && (hold == HOLD_W'(LONG_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
      end else if (!stable) begin
         hold <= '0;
      end else if (hold != HOLD_W'(LONG_CYC)) begin
         hold <= hold + 1'b1;
      end
   end

   // A release landing on the long-press cycle wins; the press is over anyway.
   always_comb begin
      evt      = db_done | long_hit;
      evt_type = EVT_LONG;
      if (db_done) evt_type = synced ? EVT_PRESS : EVT_RELEASE;
   end
`else
   assign evt      = db_done;
   assign evt_type = synced ? EVT_PRESS : EVT_RELEASE;
`endif

endmodule

// File: rtl/push_sw_event.sv
// Switch reader top: per-channel debounce, pending event slots, fixed-priority pick
// and a valid/ready output register. Long-press events exist only with PUSH_SW_LONG_EN.
module push_sw_event
   import push_sw_pkg::*;
#(
   parameter int NSW          = 4,
   parameter int DEBOUNCE_CYC = 16,
   parameter int LONG_CYC     = 1000,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic                    iSysClk,
   input  logic                    iSysRst,
   input  logic [NSW-1:0]          iSw,
   output logic [NSW-1:0]          oSwLevel,
   output logic                    oEvtValid,
   input  logic                    iEvtReady,
   output logic [1+$clog2(NSW):0]  oEvtCode,
   output logic                    oOverflow
);

   localparam int IDX_W = $clog2(NSW);

   logic [NSW-1:0]   ch_evt;
   logic [1:0]       ch_type [NSW];
   evt_slot_t        slot    [NSW];
   logic [NSW-1:0]   take;
   logic             any_full;
   logic             load;
   logic [IDX_W-1:0] pick;

   for (genvar g = 0; g < NSW; g++) begin : g_chan
      push_sw_chan #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_chan (
         .clk      (iSysClk),
         .rst      (iSysRst),
         .sw_pin   (iSw[g]),
         .level    (oSwLevel[g]),
         .evt      (ch_evt[g]),
         .evt_type (ch_type[g])
      );
   end

   // Scan from the top so the lowest-index full slot is the one left in pick.
   always_comb begin
      pick     = '0;
      any_full = 1'b0;
      for (int i = NSW - 1; i >= 0; i--) begin
         if (slot[i].full) begin
            pick     = IDX_W'(i);
            any_full = 1'b1;
         end
      end
   end

   assign load = (!oEvtValid || iEvtReady) && any_full;

   always_comb begin
      take = '0;
      for (int i = 0; i < NSW; i++) take[i] = load && (pick == IDX_W'(i));
   end

   always_ff @(posedge iSysClk or posedge iSysRst) begin
      if (iSysRst) begin
         for (int i = 0; i < NSW; i++) slot[i] <= SLOT_EMPTY;
         oOverflow <= 1'b0;
      end else begin
         for (int i = 0; i < NSW; i++) begin
            if (ch_evt[i]) begin
               if (slot[i].full && !take[i]) oOverflow <= 1'b1;
               else slot[i] <= '{full: 1'b1, typ: evt_type_e'(ch_type[i])};
            end else if (take[i]) begin
               slot[i].full <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge iSysClk or posedge iSysRst) begin
      if (iSysRst) begin
         oEvtValid <= 1'b0;
         oEvtCode  <= '0;
      end else if (load) begin
         oEvtValid <= 1'b1;
         oEvtCode  <= {slot[pick].typ, pick};
      end else if (iEvtReady) begin
         oEvtValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_push_sw_event.sv
// Bench for push_sw_event: directed switch patterns, expected codes queued at
// stimulus time and checked by an independent output monitor.
module tb_push_sw_event;

   localparam int NSW = 4;
   localparam int DB  = 8;
   localparam int LC  = 40;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic [3:0] sw    = '0;
   logic       ready = 1'b0;
   logic [3:0] level;
   logic       valid;
   logic [3:0] code;
   logic       ovf;

   int         n_cmp     = 0;
   int         n_bad     = 0;
   int         cyc_n     = 0;
   int         rise1_cyc = -1;
   int         long_cyc  = -1;
   logic       lvl1_d    = 1'b0;
   logic [3:0] mon_exp;
   logic [3:0] exp_q [$];
   int         pop_cyc [$];

   always #5 clk = ~clk;

   push_sw_event #(
      .NSW          (NSW),
      .DEBOUNCE_CYC (DB),
      .LONG_CYC     (LC),
      .ACTIVE_LOW   (0)
   ) dut (
      .iSysClk   (clk),
      .iSysRst   (rst),
      .iSw       (sw),
      .oSwLevel  (level),
      .oEvtValid (valid),
      .iEvtReady (ready),
      .oEvtCode  (code),
      .oOverflow (ovf)
   );

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: a transfer happens on the next posedge when valid && ready here.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_event: got code %b expected none", code);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("event_code", {28'd0, code}, {28'd0, mon_exp});
            end
            pop_cyc.push_back(cyc_n);
            if (code == 4'b1001) long_cyc = cyc_n;
         end
         if (level[1] && !lvl1_d) rise1_cyc = cyc_n;
         lvl1_d = level[1];
      end
   end

   initial begin
      int w;

      // reset state
      cyc(3);
      chk("rst_level", {28'd0, level}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_code",  {28'd0, code},  32'd0);
      chk("rst_ovf",   {31'd0, ovf},   32'd0);
      rst = 1'b0;
      cyc(2);

      // 1: single press, level within 10 cycles, one event
      ready = 1'b1;
      exp_q.push_back(4'b0000);
      sw[0] = 1'b1;
      w = 0;
      while (!level[0] && w < 15) begin
         cyc(1);
         w++;
      end
      chk("t1_level_within_10", {31'd0, (level[0] && w <= 10)}, 32'd1);
      cyc(30 - w);
      chk("t1_drained", exp_q.size(), 32'd0);
      exp_q.push_back(4'b0100);
      sw[0] = 1'b0;
      cyc(20);
      chk("t1_release_drained", exp_q.size(), 32'd0);
      chk("t1_level_low", {31'd0, level[0]}, 32'd0);

      // 2: bouncing pin then held -> single press only
      exp_q.push_back(4'b0001);
      for (int k = 0; k < 10; k++) begin
         sw[1] = ~sw[1];
         cyc(3);
      end
      sw[1] = 1'b1;
      cyc(20);
      chk("t2_level", {31'd0, level[1]}, 32'd1);
      chk("t2_drained", exp_q.size(), 32'd0);
      exp_q.push_back(4'b0101);
      sw[1] = 1'b0;
      cyc(20);
      chk("t2_release_drained", exp_q.size(), 32'd0);

      // 3: simultaneous presses -> index order, back to back
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0010);
      sw[0] = 1'b1;
      sw[2] = 1'b1;
      cyc(20);
      chk("t3_drained", exp_q.size(), 32'd0);
      chk("t3_back_to_back", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 32'd1);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0110);
      sw[0] = 1'b0;
      sw[2] = 1'b0;
      cyc(20);
      chk("t3_release_drained", exp_q.size(), 32'd0);

      // 4: stalled consumer, slot holds release, second press dropped
      ready = 1'b0;
      sw[3] = 1'b1;
      cyc(12);
      sw[3] = 1'b0;
      cyc(12);
      sw[3] = 1'b1;
      cyc(12);
      chk("t4_valid", {31'd0, valid}, 32'd1);
      chk("t4_code",  {28'd0, code},  32'h3);
      chk("t4_ovf",   {31'd0, ovf},   32'd1);
      cyc(5);
      chk("t4_hold_code", {27'd0, valid, code}, 32'h13);
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0111);
      ready = 1'b1;
      cyc(15);
      chk("t4_drained", exp_q.size(), 32'd0);
      chk("t4_level", {31'd0, level[3]}, 32'd1);
      exp_q.push_back(4'b0111);
      sw[3] = 1'b0;
      cyc(20);
      chk("t4_release_drained", exp_q.size(), 32'd0);
      chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);

      // 5: reset mid-debounce clears everything at once
      sw[2] = 1'b1;
      cyc(5);
      rst = 1'b1;
      #1;
      chk("t5_level", {28'd0, level}, 32'd0);
      chk("t5_valid", {31'd0, valid}, 32'd0);
      chk("t5_code",  {28'd0, code},  32'd0);
      chk("t5_ovf",   {31'd0, ovf},   32'd0);
      sw[2] = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(30);
      chk("t5_quiet", {27'd0, valid, level}, 32'd0);

      // 6: long hold
      exp_q.push_back(4'b0001);
`ifdef PUSH_SW_LONG_EN
      exp_q.push_back(4'b1001);
`endif
      exp_q.push_back(4'b0101);
      sw[1] = 1'b1;
      cyc(60);
      sw[1] = 1'b0;
      cyc(25);
      chk("t6_drained", exp_q.size(), 32'd0);
`ifdef PUSH_SW_LONG_EN
      chk("t6_long_delay", {31'd0, (long_cyc - rise1_cyc >= 39 && long_cyc - rise1_cyc <= 43)}, 32'd1);
`else
      chk("t6_no_long", long_cyc, 32'hFFFF_FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
